// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, R-type funct values and the R-type ALUop marker.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_MULA = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_e;

    localparam logic [3:0] RTYPE_OP = 4'b1111;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_MULA = 6'b111000;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct lookup; unsupported functs fall back to ADD and raise illegal.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FUNCT_SLL:  code = ALU_SLL;
            FUNCT_SRL:  code = ALU_SRL;
            FUNCT_SRA:  code = ALU_SRA;
            FUNCT_ADD:  code = ALU_ADD;
            FUNCT_ADDU: code = ALU_ADDU;
            FUNCT_SUB:  code = ALU_SUB;
            FUNCT_SUBU: code = ALU_SUBU;
            FUNCT_AND:  code = ALU_AND;
            FUNCT_OR:   code = ALU_OR;
            FUNCT_XOR:  code = ALU_XOR;
            FUNCT_NOR:  code = ALU_NOR;
            FUNCT_SLT:  code = ALU_SLT;
            FUNCT_SLTU: code = ALU_SLTU;
            FUNCT_MULA: code = ALU_MULA;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// ALU control: selects funct decode for R-type or passes ALUop through, registered with one cycle latency.
module alu_control
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ALUop,
    input  logic [5:0] FuncCode,
    output logic [3:0] ALUCtrl,
    output logic       IllegalFunc
);

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic [3:0] next_ctrl;
    logic       next_illegal;

    alu_funct_decode u_decode (
        .funct   (FuncCode),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    // Non-R-type ops never look at the decoder, so a don't-care FuncCode cannot leak out.
    always_comb begin
        next_ctrl    = ALUop;
        next_illegal = 1'b0;
        if (ALUop == RTYPE_OP) begin
            next_ctrl    = dec_code;
            next_illegal = dec_illegal;
        end else begin
            next_ctrl    = ALUop;
            next_illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUCtrl     <= 4'b0000;
            IllegalFunc <= 1'b0;
        end else begin
            ALUCtrl     <= next_ctrl;
            IllegalFunc <= next_illegal;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: expectations queued at drive time, compared after each edge.
module tb_alu_control;

    logic       clk;
    logic       rst;
    logic [3:0] ALUop;
    logic [5:0] FuncCode;
    logic [3:0] ALUCtrl;
    logic       IllegalFunc;

    int errors;
    int checks;
    logic [4:0] expect_q[$];

    alu_control dut (
        .clk         (clk),
        .rst         (rst),
        .ALUop       (ALUop),
        .FuncCode    (FuncCode),
        .ALUCtrl     (ALUCtrl),
        .IllegalFunc (IllegalFunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the opcode table, packed as {code, illegal}.
    function automatic logic [4:0] model(input logic r, input logic [3:0] op, input logic [5:0] fc);
        if (r) return 5'b0000_0;
        if (op != 4'b1111) return {op, 1'b0};
        case (fc)
            6'b000000: return {4'b0011, 1'b0};
            6'b000010: return {4'b0100, 1'b0};
            6'b000011: return {4'b1101, 1'b0};
            6'b100000: return {4'b0010, 1'b0};
            6'b100001: return {4'b1000, 1'b0};
            6'b100010: return {4'b0110, 1'b0};
            6'b100011: return {4'b1001, 1'b0};
            6'b100100: return {4'b0000, 1'b0};
            6'b100101: return {4'b0001, 1'b0};
            6'b100110: return {4'b1010, 1'b0};
            6'b100111: return {4'b1100, 1'b0};
            6'b101010: return {4'b0111, 1'b0};
            6'b101011: return {4'b1011, 1'b0};
            6'b111000: return {4'b0101, 1'b0};
            default:   return {4'b0010, 1'b1};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got ALUCtrl=%b IllegalFunc=%b, expected ALUCtrl=%b IllegalFunc=%b",
                     tag, got[4:1], got[0], exp[4:1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, then compare after the capturing edge.
    task automatic applyStimulus(input string tag, input logic r, input logic [3:0] op, input logic [5:0] fc);
        logic [4:0] exp;
        @(negedge clk);
        rst      = r;
        ALUop    = op;
        FuncCode = fc;
        expect_q.push_back(model(r, op, fc));
        @(posedge clk);
        #1;
        if (expect_q.size() == 0) begin
            checkOutput({tag, "_noexp"}, 5'b11111, 5'b00000);
        end else begin
            exp = expect_q.pop_front();
            checkOutput(tag, {ALUCtrl, IllegalFunc}, exp);
        end
    endtask

    logic [5:0] legal_functs [14] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000,
                                       6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                       6'b100101, 6'b100110, 6'b100111, 6'b101010,
                                       6'b101011, 6'b111000};
    logic [5:0] bad_functs [4] = '{6'b001000, 6'b000001, 6'b111111, 6'b101000};

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        ALUop    = 4'b0010;
        FuncCode = 6'b000000;

        applyStimulus("reset0", 1'b1, 4'b0010, 6'b000000);
        applyStimulus("reset1", 1'b1, 4'b0010, 6'b000000);
        applyStimulus("post_reset", 1'b0, 4'b0010, 6'b000000);

        for (int i = 0; i < 14; i++)
            applyStimulus("rtype", 1'b0, 4'b1111, legal_functs[i]);

        for (int i = 0; i < 15; i++)
            applyStimulus("passthru", 1'b0, 4'(i), 6'bxxxxxx);

        applyStimulus("illegal_001000", 1'b0, 4'b1111, 6'b001000);
        applyStimulus("and_after_illegal", 1'b0, 4'b1111, 6'b100100);
        for (int i = 0; i < 4; i++)
            applyStimulus("illegal", 1'b0, 4'b1111, bad_functs[i]);
        applyStimulus("itype_after_illegal", 1'b0, 4'b0111, 6'b001000);

        for (int i = 0; i < 6; i++) begin
            applyStimulus("b2b_sub", 1'b0, 4'b1111, 6'b100010);
            applyStimulus("b2b_subu", 1'b0, 4'b1001, 6'bxxxxxx);
        end
        applyStimulus("b2b_sub", 1'b0, 4'b1111, 6'b100010);
        applyStimulus("mid_reset", 1'b1, 4'b1001, 6'b100010);
        applyStimulus("resume_sub", 1'b0, 4'b1111, 6'b100010);
        applyStimulus("resume_subu", 1'b0, 4'b1001, 6'bxxxxxx);

        if (expect_q.size() != 0)
            checkOutput("queue_drained", 5'b11111, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- Decodes the main controller's 4-bit ALUop and the R-type instruction funct field (FuncCode) into the 4-bit ALU operation select (ALUCtrl) for the MIPS datapath ALU.
- ALUop 4'b1111 marks an R-type instruction, which is decoded from FuncCode.
- Any other ALUop value is an immediate, I-type or LUI operation and passes straight through as the ALU code.
- Output is registered: one clock of latency, synchronous active-high reset.

Parameters:
- RTYPE_OP, 4'b1111, ALUop value that selects funct-field decoding.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ALUop  input  4  operation class from the main control unit.
- FuncCode  input  6  instruction bits [5:0] (funct); may be X/don't-care when ALUop != RTYPE_OP.
- ALUCtrl  output  4  registered ALU operation code.
- IllegalFunc  output  1  registered flag: R-type with an unsupported funct.

Behaviour:
- ALU codes: AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100, MULA=0101, SUB=0110, SLT=0111, ADDU=1000, SUBU=1001, XOR=1010, SLTU=1011, NOR=1100, SRA=1101, LUI=1110.
- Funct codes map as follows:
  - 000000->SLL, 000010->SRL, 000011->SRA
  - 100000->ADD, 100001->ADDU, 100010->SUB, 100011->SUBU
  - 100100->AND, 100101->OR, 100110->XOR, 100111->NOR
  - 101010->SLT, 101011->SLTU, 111000->MULA
- ALUop == 4'b1111 with a listed funct: next ALUCtrl = mapped code, IllegalFunc = 0.
- ALUop == 4'b1111 with an unlisted funct: next ALUCtrl = ADD (0010), IllegalFunc = 1.
- ALUop != 4'b1111: next ALUCtrl = ALUop unchanged (all 15 codes 0000..1110), IllegalFunc = 0.
  - FuncCode is ignored completely in this case.
  - X/Z on FuncCode must not propagate to the outputs. Use a full if/else on ALUop with no casex/casez on FuncCode.
- Timing:
  - Decode is combinational and is captured on each rising clk edge.
  - Outputs reflect the inputs sampled at the previous edge (latency 1 cycle).
  - Throughput is one decode per cycle; there is no handshake.
- Reset:
  - When rst = 1 at a rising edge: ALUCtrl <= 4'b0000 and IllegalFunc <= 0. Reset takes priority over decode.
  - Reset asserted mid-stream discards the pending decode. The first post-reset decode appears one cycle after rst deasserts.
- No internal state other than the two output registers.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU operation codes (enum or localparams),
  - the 6-bit funct constants,
  - RTYPE_OP.
- The datapath ALU imports the same package.
- One natural sub-module is alu_funct_decode: a purely combinational funct -> {code, illegal} lookup. The top-level alu_control adds the ALUop mux and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with ALUop=0010 -> ALUCtrl=0000, IllegalFunc=0. Deassert rst -> ALUCtrl=0010 one cycle later.
- R-type sweep: ALUop=1111 with each listed funct, one per cycle, e.g. 000000->0011, 000011->1101, 100001->1000, 100111->1100, 101011->1011, 111000->0101. Each result appears the following cycle with IllegalFunc=0.
- I-type passthrough: ALUop swept over 0000..1110 with FuncCode=6'bxxxxxx -> ALUCtrl equals ALUop one cycle later, never X, IllegalFunc=0. Include 0001 (ORI), 0111 (SLTI), 1010 (XORI) and 1110 (LUI).
- Illegal funct: ALUop=1111, FuncCode=001000 -> ALUCtrl=0010, IllegalFunc=1. Next cycle apply 100100 -> ALUCtrl=0000, IllegalFunc=0.
- Back-to-back and mid-stream reset: alternate ALUop=1111/FuncCode=100010 and ALUop=1001 every cycle -> ALUCtrl alternates 0110 and 1001 with 1-cycle lag. Assert rst during the stream -> 0000 on the next edge.
